// File: rtl/rv_mdu_pkg.sv
// M-extension operation codes and op-class helpers for the multiply/divide unit.
package rv_mdu_pkg;

    localparam int MDU_OP_W = 3;

    // Encodings follow the funct3 field of the M-extension opcodes.
    localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

    function automatic logic is_mul(input logic [MDU_OP_W-1:0] op);
        return !op[2];
    endfunction

    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/rv_pkg.sv
// Core-wide constants shared by the RV32IM execute stage.
package rv_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/rv_div.sv
// Iterative restoring divider: one quotient bit per cycle, producing quotient
// and remainder together so a DIV/REM pair can share a single run.
module rv_div
#(
    parameter int XLEN = rv_pkg::XLEN
)
(
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            div_start_i,
    input  logic            zero_i,
    input  logic            kill_i,
    input  logic            keep_i,
    input  logic            signed_i,
    input  logic [XLEN-1:0] port_a_i,
    input  logic [XLEN-1:0] port_b_i,
    output logic [XLEN-1:0] div_result_o,
    output logic [XLEN-1:0] rem_result_o,
    output logic            div_stall_req_o
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {D_IDLE, D_INIT, D_CALC, D_ZERO, D_SIGN, D_DONE} div_state_e;

    div_state_e        state, state_nxt;
    logic [XLEN-1:0]   a_p0, b_p0;
    logic              sgn_p0;
    logic [XLEN-1:0]   quo_p1, dvs_p1, rem_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              neg_q_p1, neg_r_p1;
    logic              need_sign;
    logic              last_step;
    logic [XLEN:0]     rem_shift, diff;
    logic [XLEN-1:0]   q_nxt, r_nxt;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

    assign need_sign = neg_q_p1 | neg_r_p1;
    assign last_step = (cnt_p1 == CNT_W'(XLEN-1));

    // One restoring step: shift in the next dividend bit, try the subtraction.
    always_comb begin
        rem_shift = {rem_p1, quo_p1[XLEN-1]};
        diff      = rem_shift - {1'b0, dvs_p1};
        q_nxt     = {quo_p1[XLEN-2:0], ~diff[XLEN]};
        r_nxt     = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    end

    assign div_stall_req_o = (state == D_IDLE) ? div_start_i : (state != D_DONE);

    // State register; reset comes in active-low and is sampled on the clock.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) state <= D_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: zero divisor short-cuts, sign fix-up only when needed.
    always_comb begin
        state_nxt = state;
        case (state)
            D_IDLE: if (div_start_i) state_nxt = zero_i ? D_ZERO : D_INIT;
            D_INIT: state_nxt = D_CALC;
            D_CALC: if (last_step) state_nxt = need_sign ? D_SIGN : D_DONE;
            D_ZERO: state_nxt = D_DONE;
            D_SIGN: state_nxt = D_DONE;
            D_DONE: if (!keep_i) state_nxt = D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
        if (kill_i) state_nxt = D_IDLE;
    end

    // Operand capture, magnitude set-up and the shift/subtract iteration.
    always_ff @(posedge clk_i) begin
        case (state)
            D_IDLE: begin
                a_p0   <= port_a_i;
                b_p0   <= port_b_i;
                sgn_p0 <= signed_i;
            end
            D_INIT: begin
                quo_p1   <= cond_neg(a_p0, sgn_p0 & a_p0[XLEN-1]);
                dvs_p1   <= cond_neg(b_p0, sgn_p0 & b_p0[XLEN-1]);
                rem_p1   <= '0;
                cnt_p1   <= '0;
                neg_q_p1 <= sgn_p0 & (a_p0[XLEN-1] ^ b_p0[XLEN-1]);
                neg_r_p1 <= sgn_p0 & a_p0[XLEN-1];
            end
            D_CALC: begin
                quo_p1 <= q_nxt;
                rem_p1 <= r_nxt;
                cnt_p1 <= cnt_p1 + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Result registers hold the last completed run for the cache to reuse.
    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            div_result_o <= '0;
            rem_result_o <= '0;
        end else if (!kill_i) begin
            case (state)
                D_CALC: if (last_step && !need_sign) begin
                    div_result_o <= q_nxt;
                    rem_result_o <= r_nxt;
                end
                D_ZERO: begin
                    div_result_o <= '1;
                    rem_result_o <= a_p0;
                end
                D_SIGN: begin
                    div_result_o <= cond_neg(quo_p1, neg_q_p1);
                    rem_result_o <= cond_neg(rem_p1, neg_r_p1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rv_mdu.sv
// RV32IM multiply/divide front-end: 2-cycle multiplier, iterative divider
// control, DIV/REM operand cache and the single result/stall seen by EX.
module rv_mdu
    import rv_mdu_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
)
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                mdu_req_i,
    input  logic [MDU_OP_W-1:0] mdu_op_i,
    input  logic [XLEN-1:0]     port_a_i,
    input  logic [XLEN-1:0]     port_b_i,
    input  logic                kill_i,
    input  logic                keep_i,
    output logic [XLEN-1:0]     mdu_result_o,
    output logic                mdu_stall_req_o
);

    typedef enum logic [1:0] {M_IDLE, M_CALC, M_DONE} mul_state_e;

    mul_state_e               m_state, m_nxt;
    logic                     mul_req, div_req, div_signed;
    logic                     a_sext, b_sext;
    logic signed [XLEN:0]     mul_a_p0, mul_b_p0;
    logic signed [2*XLEN+1:0] product_p1;
    logic                     mul_unused_hi;

    logic                     cache_valid, cache_signed, cache_hit;
    logic [XLEN-1:0]          cache_a, cache_b;

    logic                     div_start, div_zero, div_stall;
    logic [XLEN-1:0]          div_result, rem_result;

    assign mul_req    = mdu_req_i & is_mul(mdu_op_i);
    assign div_req    = mdu_req_i & is_div(mdu_op_i);
    assign div_signed = (mdu_op_i == MDU_DIV) | (mdu_op_i == MDU_REM);
    assign a_sext     = (mdu_op_i == MDU_MULH) | (mdu_op_i == MDU_MULHSU);
    assign b_sext     = (mdu_op_i == MDU_MULH);

    // Multiplier state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) m_state <= M_IDLE;
        else       m_state <= m_nxt;
    end

    // Multiplier sequencing; a flush wins over everything.
    always_comb begin
        m_nxt = m_state;
        case (m_state)
            M_IDLE: if (mul_req) m_nxt = M_CALC;
            M_CALC: m_nxt = M_DONE;
            M_DONE: if (!keep_i) m_nxt = M_IDLE;
            default: m_nxt = M_IDLE;
        endcase
        if (kill_i) m_nxt = M_IDLE;
    end

    // Stage 0: 33-bit operands, extended per op so one signed multiply covers all variants.
    always_ff @(posedge clk_i) begin
        if (m_state == M_IDLE && mul_req && !kill_i) begin
            mul_a_p0 <= {a_sext & port_a_i[XLEN-1], port_a_i};
            mul_b_p0 <= {b_sext & port_b_i[XLEN-1], port_b_i};
        end
    end

    // Stage 1: full signed product.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            product_p1 <= '0;
        else if (m_state == M_CALC && !kill_i)
            product_p1 <= (2*XLEN+2)'(mul_a_p0) * (2*XLEN+2)'(mul_b_p0);
    end

    // The two extension bits of the product never reach the result.
    assign mul_unused_hi = ^product_p1[2*XLEN+1:2*XLEN];

    assign cache_hit = div_req & cache_valid & (port_a_i == cache_a) &
                       (port_b_i == cache_b) & (div_signed == cache_signed);
    assign div_start = div_req & ~cache_hit;
    assign div_zero  = (port_b_i == '0);

    // Cache valid: dropped while a divide runs, set when one completes.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cache_valid <= 1'b0;
        else if (div_start && div_stall)
            cache_valid <= 1'b0;
        else if (div_start && !div_stall && !kill_i)
            cache_valid <= 1'b1;
    end

    // Cache tag: operands and signedness of the completed divide.
    always_ff @(posedge clk_i) begin
        if (div_start && !div_stall && !kill_i) begin
            cache_a      <= port_a_i;
            cache_b      <= port_b_i;
            cache_signed <= div_signed;
        end
    end

    rv_div #(.XLEN(XLEN)) u_div (
        .clk_i           (clk_i),
        .arstn_i         (~rst_i),
        .div_start_i     (div_start),
        .zero_i          (div_zero),
        .kill_i          (kill_i),
        .keep_i          (keep_i),
        .signed_i        (div_signed),
        .port_a_i        (port_a_i),
        .port_b_i        (port_b_i),
        .div_result_o    (div_result),
        .rem_result_o    (rem_result),
        .div_stall_req_o (div_stall)
    );

    // Result mux and stall request toward EX.
    always_comb begin
        mdu_result_o    = '0;
        mdu_stall_req_o = 1'b0;
        if (mul_req) begin
            mdu_stall_req_o = (m_state != M_DONE);
            if (m_state == M_DONE)
                mdu_result_o = (mdu_op_i == MDU_MUL) ? product_p1[XLEN-1:0]
                                                     : product_p1[2*XLEN-1:XLEN];
        end else if (div_req) begin
            mdu_stall_req_o = cache_hit ? 1'b0 : div_stall;
            mdu_result_o    = ((mdu_op_i == MDU_DIV) || (mdu_op_i == MDU_DIVU)) ? div_result
                                                                                 : rem_result;
        end
    end

endmodule

// File: tb/tb_rv_mdu.sv
// Scoreboard bench for rv_mdu: driver pushes expected result, stall count and
// divider-start flag; monitor checks every cycle the DUT presents a result.
module tb_rv_mdu;
    import rv_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        kill = 1'b0;
    logic        keep = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] result;
    logic        stall;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          stalls;
        logic        starts;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    rv_mdu dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mdu_req_i       (req),
        .mdu_op_i        (op),
        .port_a_i        (a),
        .port_b_i        (b),
        .kill_i          (kill),
        .keep_i          (keep),
        .mdu_result_o    (result),
        .mdu_stall_req_o (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: count stall cycles per request, compare whenever a result is presented.
    initial begin
        int   stall_cnt;
        bit   saw_start;
        exp_t e;
        stall_cnt = 0;
        saw_start = 0;
        wait (!rst);
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_result", result, 32'd0);
        forever begin
            @(negedge clk);
            if (!req) begin
                stall_cnt = 0;
                saw_start = 0;
            end else begin
                if (dut.div_start) saw_start = 1;
                if (stall) begin
                    stall_cnt++;
                end else if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%08h, expected no result", result);
                end else begin
                    e = sb[0];
                    check({e.name, "_result"}, result, e.res);
                    check({e.name, "_stalls"}, 32'(stall_cnt), 32'(e.stalls));
                    check({e.name, "_div_start"}, {31'd0, saw_start}, {31'd0, e.starts});
                    if (!keep) begin
                        void'(sb.pop_front());
                        stall_cnt = 0;
                        saw_start = 0;
                    end
                end
            end
        end
    end

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n++;
            if (n > 200) begin
                $display("FAIL %s_timeout: stall high for %0d cycles, expected release within 200", nm, n);
                $fatal(1, "stall never released");
            end
        end
    endtask

    // Issue one request; keep_n > 0 holds the finished result for keep_n cycles.
    task automatic issue(input string nm, input logic [2:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic [31:0] er, input int es,
                         input logic st, input int keep_n);
        exp_t e;
        e.name = nm; e.res = er; e.stalls = es; e.starts = st;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b1; op = o; a = aa; b = bb; keep = (keep_n > 0);
        wait_valid(nm);
        repeat (keep_n) begin @(posedge clk); #1; end
        keep = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    // Start a DIV and flush it while it is in its 10th cycle.
    task automatic issue_killed(input logic [31:0] aa, input logic [31:0] bb);
        @(posedge clk); #1;
        req = 1'b1; op = MDU_DIV; a = aa; b = bb;
        repeat (9) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        req  = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        issue("mulh_min",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 2, 1'b0, 0);
        issue("mul_min",    MDU_MUL,    32'h80000000, 32'h80000000, 32'h00000000, 2, 1'b0, 0);
        issue("mulhsu_m1",  MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0, 0);
        issue("mulhu_max",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0, 0);
        issue("div_m7_2",   MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 35, 1'b1, 0);
        issue("rem_m7_2",   MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 1'b0, 0);
        issue("divu_5_0",   MDU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 2, 1'b1, 0);
        issue("remu_5_0",   MDU_REMU,   32'd5,        32'd0,        32'd5,        0, 1'b0, 0);
        issue("div_ovf",    MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 35, 1'b1, 0);
        issue("rem_ovf",    MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0, 0);
        issue("divu_100_7", MDU_DIVU,   32'd100,      32'd7,        32'd14,       34, 1'b1, 0);
        issue("remu_100_7", MDU_REMU,   32'd100,      32'd7,        32'd2,        0, 1'b0, 0);
        issue_killed(32'd100, 32'hFFFFFFF9);
        issue("rem_after_kill", MDU_REM, 32'd100,     32'hFFFFFFF9, 32'd2,        35, 1'b1, 0);
        issue("mulhu_keep", MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1'b0, 3);
        issue("div_hit_after_rem", MDU_DIV, 32'd100,  32'hFFFFFFF9, 32'hFFFFFFF2, 0, 1'b0, 0);

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
